lcd_receiver: RTL and testbench

Synthesizable HD44780-subset character-LCD responder: the device end of the 8-bit `lcd_data` / `lcd_ctrl` / `lcd_enable` bus that the CPU drives through memory-mapped registers. It sits outside the SoC top in simulation and FPGA display-emulation builds. It decodes commands and data on each falling edge of `lcd_enable`, maintains DDRAM, the address counter and the display flags, and models the busy flag. It also exposes a read port so a scanout or checker can read displayed characters.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_receiver_sync_edge_detect.sv | 28 ++
 rtl/lcd_receiver.sv | 178 +++++++++++++++++
 tb/tb_lcd_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared encodings for the character-LCD responder: bus control codes,
// FSM states, command prefixes and the blank character.
package lcd_pkg;

    localparam logic [1:0] LCD_CMD    = 2'b00;
    localparam logic [1:0] LCD_STATUS = 2'b01;
    localparam logic [1:0] LCD_DWR    = 2'b10;
    localparam logic [1:0] LCD_DRD    = 2'b11;

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        BUSY
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPLAY = 8'h08;
    localparam logic [7:0] CMD_SHIFT   = 8'h10;
    localparam logic [7:0] CMD_FUNC    = 8'h20;
    localparam logic [7:0] CMD_CGRAM   = 8'h40;
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    localparam logic [7:0] SPACE_CHAR = 8'h20;

    // Commands are identified by their most significant set bit.
    function automatic logic [7:0] top_bit(input logic [7:0] v);
        top_bit = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) top_bit = 8'h01 << i;
        end
    endfunction

endpackage

// File: rtl/lcd_receiver_sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous enable strobe, with one
// extra history flop to produce single-cycle rise and fall pulses.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/lcd_receiver.sv
// HD44780-subset LCD device model: DDRAM, address counter, display flags,
// busy flag and a scanout read port. Define LCD_RX_TRACE_EN to echo data writes.
module lcd_receiver
    import lcd_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int BUSY_CYCLES = 40,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    lcd_data,
    input  logic [1:0]    lcd_ctrl,
    input  logic          lcd_enable,
    output logic [7:0]    lcd_rdata,
    output logic          busy,
    output logic          overrun,
    output logic          char_valid,
    output logic [7:0]    char_out,
    output logic          display_on,
    output logic          cursor_on,
    output logic          blink_on,
    output logic [AW-1:0] cursor_addr,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_char
);

    localparam int CW = $clog2(BUSY_CYCLES + 1);

    logic          rise, fall;
    logic [7:0]    data_d1, data_d;
    logic [1:0]    ctrl_d1, ctrl_d;
    lcd_state_t    state;
    logic [AW-1:0] fill_idx, ac, ac_step;
    logic [CW-1:0] busy_cnt;
    logic          inc;
    logic [7:0]    mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          wr_edge, rd_edge;

    sync_edge_detect u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (lcd_enable),
        .rise     (rise),
        .fall     (fall)
    );

    // Data/ctrl ride two flops so they line up with the synchronized strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_d1 <= 8'h00;
            data_d  <= 8'h00;
            ctrl_d1 <= 2'b00;
            ctrl_d  <= 2'b00;
        end else begin
            data_d1 <= lcd_data;
            data_d  <= data_d1;
            ctrl_d1 <= lcd_ctrl;
            ctrl_d  <= ctrl_d1;
        end
    end

    assign busy        = (state != IDLE);
    assign cursor_addr = ac;
    assign wr_edge     = fall && (ctrl_d == LCD_CMD || ctrl_d == LCD_DWR);
    assign rd_edge     = rise && (ctrl_d == LCD_STATUS || ctrl_d == LCD_DRD);
    assign ac_step     = inc ? ac + AW'(1) : ac - AW'(1);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ac;
        mem_wdata = data_d;
        if (state == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = fill_idx;
            mem_wdata = SPACE_CHAR;
        end else if (state == IDLE && wr_edge && ctrl_d == LCD_DWR) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_char <= 8'h00;
        else     rd_char <= mem[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            fill_idx   <= '0;
            busy_cnt   <= '0;
            ac         <= '0;
            inc        <= 1'b1;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            overrun    <= 1'b0;
            char_valid <= 1'b0;
            char_out   <= 8'h00;
            lcd_rdata  <= 8'h00;
        end else begin
            char_valid <= 1'b0;
            case (state)
                FILL: begin
                    if (fill_idx == AW'(DEPTH - 1)) begin
                        state    <= IDLE;
                        fill_idx <= '0;
                        ac       <= '0;
                        inc      <= 1'b1;
                    end else begin
                        fill_idx <= fill_idx + AW'(1);
                    end
                end
                BUSY: begin
                    if (busy_cnt == '0) state <= IDLE;
                    else                busy_cnt <= busy_cnt - CW'(1);
                end
                default: begin
                    if (wr_edge) begin
                        busy_cnt <= CW'(BUSY_CYCLES - 1);
                        if (ctrl_d == LCD_DWR) begin
                            char_valid <= 1'b1;
                            char_out   <= data_d;
                            ac         <= ac_step;
                            state      <= BUSY;
                        end else begin
                            state <= BUSY;
                            case (top_bit(data_d))
                                CMD_CLEAR:   state <= FILL;
                                CMD_HOME:    ac <= '0;
                                CMD_ENTRY:   inc <= data_d[1];
                                CMD_DISPLAY: begin
                                    display_on <= data_d[2];
                                    cursor_on  <= data_d[1];
                                    blink_on   <= data_d[0];
                                end
                                CMD_SHIFT: begin
                                    if (!data_d[3]) ac <= data_d[2] ? ac + AW'(1) : ac - AW'(1);
                                end
                                CMD_FUNC, CMD_CGRAM: ;
                                CMD_DDRAM:   ac <= data_d[AW-1:0];
                                default:     state <= IDLE;
                            endcase
                        end
                    end
                end
            endcase

            if (wr_edge && state != IDLE) overrun <= 1'b1;

            // Reads never touch busy; a data read only steps AC when idle.
            if (rd_edge) begin
                if (ctrl_d == LCD_DRD) begin
                    lcd_rdata <= mem[ac];
                    if (state == IDLE) ac <= ac_step;
                end else begin
                    lcd_rdata <= {busy, 7'(ac)};
                end
            end
        end
    end

`ifdef LCD_RX_TRACE_EN
    always @(posedge clk) begin
        if (char_valid) $write("%c", char_out);
    end
`else
    // Hardware is identical; no character echo in this build.
`endif

endmodule

// File: tb/tb_lcd_receiver.sv
// Self-checking bench for lcd_receiver: bus-level driver tasks, a DDRAM/AC
// reference model and a char_valid scoreboard fed from an expected queue.
module tb_lcd_receiver;
    import lcd_pkg::*;

    localparam int DEPTH       = 32;
    localparam int BUSY_CYCLES = 40;
    localparam int AW          = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic [7:0]    lcd_data;
    logic [1:0]    lcd_ctrl;
    logic          lcd_enable;
    logic [7:0]    lcd_rdata;
    logic          busy;
    logic          overrun;
    logic          char_valid;
    logic [7:0]    char_out;
    logic          display_on, cursor_on, blink_on;
    logic [AW-1:0] cursor_addr;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_char;

    lcd_receiver #(.DEPTH(DEPTH), .BUSY_CYCLES(BUSY_CYCLES)) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_data    (lcd_data),
        .lcd_ctrl    (lcd_ctrl),
        .lcd_enable  (lcd_enable),
        .lcd_rdata   (lcd_rdata),
        .busy        (busy),
        .overrun     (overrun),
        .char_valid  (char_valid),
        .char_out    (char_out),
        .display_on  (display_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .cursor_addr (cursor_addr),
        .rd_addr     (rd_addr),
        .rd_char     (rd_char)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_compared   = 0;
    int n_mismatched = 0;
    int n_chars      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [7:0] exp_q[$];
    logic [7:0] exp_mem [DEPTH];
    int         m_ac;
    bit         m_inc;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 8'h20;
        m_ac  = 0;
        m_inc = 1'b1;
    endtask

    function automatic int ac_next(input int a, input bit up);
        return (a + (up ? 1 : DEPTH - 1)) % DEPTH;
    endfunction

    always @(negedge clk) begin
        if (!rst && char_valid) begin
            n_chars++;
            if (exp_q.size() == 0) check("char_spurious", 32'(exp_q.size()), 1);
            else                   check("char_out", char_out, exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Data/ctrl set one cycle ahead of the strobe and held 4 cycles past its fall.
    task automatic lcd_xfer(input logic [1:0] ctrl, input logic [7:0] data);
        lcd_ctrl = ctrl;
        lcd_data = data;
        cyc(1);
        lcd_enable = 1'b1;
        cyc(3);
        lcd_enable = 1'b0;
        cyc(4);
    endtask

    task automatic wait_idle(input int budget, output int cnt);
        cnt = 0;
        while (busy && cnt < budget) begin
            cyc(1);
            cnt++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic write_cmd(input logic [7:0] b);
        int cnt;
        lcd_xfer(LCD_CMD, b);
        wait_idle(200, cnt);
    endtask

    // Model update for a data write accepted from IDLE.
    task automatic push_data(input logic [7:0] ch);
        exp_mem[m_ac] = ch;
        exp_q.push_back(ch);
        m_ac = ac_next(m_ac, m_inc);
    endtask

    task automatic write_data(input logic [7:0] ch);
        int cnt;
        push_data(ch);
        lcd_xfer(LCD_DWR, ch);
        wait_idle(200, cnt);
    endtask

    task automatic read_xfer(input logic [1:0] ctrl, output logic [7:0] r);
        lcd_xfer(ctrl, 8'h00);
        r = lcd_rdata;
    endtask

    task automatic check_mem(input string tag, input int addr);
        rd_addr = AW'(addr);
        cyc(1);
        check(tag, rd_char, exp_mem[addr]);
    endtask

    task automatic check_reset_values();
        check("rst_rdata", lcd_rdata, 0);
        check("rst_overrun", overrun, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_out", char_out, 0);
        check("rst_display", {display_on, cursor_on, blink_on}, 0);
        check("rst_cursor_addr", cursor_addr, 0);
        check("rst_rd_char", rd_char, 0);
        check("rst_busy", busy, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         cnt;
        logic [7:0] r;
        int         a;
        logic [7:0] ch;

        rst        = 1'b1;
        lcd_enable = 1'b0;
        lcd_data   = 8'h00;
        lcd_ctrl   = 2'b00;
        rd_addr    = '0;
        cyc(3);
        check_reset_values();

        rst = 1'b0;
        model_reset();
        wait_idle(200, cnt);
        check("fill_len", cnt, DEPTH);
        check_mem("fill_0", 0);
        check_mem("fill_15", 15);
        check_mem("fill_31", 31);
        check("ac_after_fill", cursor_addr, m_ac);

        // Set address to the last cell, then write across the wrap.
        write_cmd(8'h9F);
        m_ac = 31;
        check("ac_set_ddram", cursor_addr, m_ac);
        write_data(8'h41);
        write_data(8'h42);
        check("ac_after_wrap", cursor_addr, m_ac);
        check_mem("mem_31_A", 31);
        check_mem("mem_0_B", 0);
        check("char_count", n_chars, 2);

        // Home, decrement mode, write with backward wrap.
        write_cmd(8'h02);
        m_ac = 0;
        write_cmd(8'h04);
        m_inc = 1'b0;
        write_data(8'h5A);
        check("ac_dec_wrap", cursor_addr, m_ac);
        check_mem("mem_0_Z", 0);

        read_xfer(LCD_STATUS, r);
        check("status_idle", r, {1'b0, 7'(m_ac)});
        read_xfer(LCD_DRD, r);
        check("data_read", r, exp_mem[m_ac]);
        m_ac = ac_next(m_ac, m_inc);
        check("ac_after_read", cursor_addr, m_ac);

        write_cmd(8'h06);
        m_inc = 1'b1;

        // Second write lands while busy: dropped and flagged.
        check("overrun_clear", overrun, 0);
        push_data(8'h43);
        lcd_xfer(LCD_DWR, 8'h43);
        lcd_xfer(LCD_DWR, 8'h44);
        check("overrun_set", overrun, 1);
        read_xfer(LCD_STATUS, r);
        check("status_busy_bit", r[7], 1);
        read_xfer(LCD_DRD, r);
        check("data_read_busy", r, exp_mem[m_ac]);
        check("ac_read_busy", cursor_addr, m_ac);
        wait_idle(200, cnt);
        check_mem("mem_31_kept", 31);
        check_mem("mem_30_C", 30);
        check("ac_after_overrun", cursor_addr, m_ac);

        // Display control, with busy-length measurement.
        lcd_xfer(LCD_CMD, 8'h0E);
        wait_idle(200, cnt);
        check("busy_len", cnt + 1, BUSY_CYCLES);
        check("display_flags", {display_on, cursor_on, blink_on}, 3'b110);

        lcd_xfer(LCD_CMD, 8'h00);
        check("nop_not_busy", busy, 0);

        // Clear refills DDRAM and resets AC.
        lcd_xfer(LCD_CMD, 8'h01);
        wait_idle(200, cnt);
        check("clear_len", cnt + 1, DEPTH);
        model_reset();
        for (int i = 0; i < DEPTH; i++) check_mem("clear_mem", i);
        check("ac_after_clear", cursor_addr, m_ac);
        check("overrun_sticky", overrun, 1);

        // Cursor shifts: left wraps, right wraps back, display shift ignored.
        write_cmd(8'h10);
        m_ac = ac_next(m_ac, 1'b0);
        check("shift_left", cursor_addr, m_ac);
        write_cmd(8'h14);
        m_ac = ac_next(m_ac, 1'b1);
        check("shift_right", cursor_addr, m_ac);
        write_cmd(8'h18);
        check("shift_display", cursor_addr, m_ac);

        for (int k = 0; k < 4; k++) begin
            a  = int'($urandom_range(0, DEPTH - 1));
            ch = 8'($urandom_range(8'h21, 8'h7E));
            write_cmd(8'h80 | 8'(a));
            m_ac = a;
            write_data(ch);
            check_mem("rand_mem", a);
            check("rand_ac", cursor_addr, m_ac);
        end

        // Reset during BUSY aborts and restarts the fill.
        a = m_ac;
        push_data(8'h51);
        lcd_xfer(LCD_DWR, 8'h51);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        cyc(2);
        check_reset_values();
        rst = 1'b0;
        model_reset();
        wait_idle(200, cnt);
        check("fill_len_again", cnt, DEPTH);
        check_mem("refill_q_addr", a);
        check("ac_after_refill", cursor_addr, m_ac);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
